// File: rtl/psc_trigger_pkg.sv
// Shared constants and types for the PSC trigger link. The frame transmitter
// imports the same K-characters and trigger pattern so both ends agree.
package psc_trigger_pkg;

   localparam logic [7:0] PSC_SOP         = 8'h3C;  // K28.1
   localparam logic [7:0] PSC_EOP         = 8'hBC;  // K28.5
   localparam int         PSC_PAYLOAD_LEN = 8;
   localparam logic [7:0] PSC_TRIG_B0     = 8'h01;
   localparam logic [7:0] PSC_TRIG_B1     = 8'h30;
   localparam int         PSC_TIMEOUT     = 64;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PAYLOAD  = 2'd1,
      EOP_WAIT = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BAD_K   = 2'd1,
      ERR_BAD_EOP = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

endpackage

// File: rtl/psc_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module psc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (i_inc && (r_count != {W{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/psc_trigger_frame_rx.sv
// Parses SOP / payload / EOP frames from the decoded link byte stream and
// reports good frames, trigger frames and framing errors.
module psc_trigger_frame_rx
   import psc_trigger_pkg::*;
#(
   parameter logic [7:0] SOP         = PSC_SOP,
   parameter logic [7:0] EOP         = PSC_EOP,
   parameter int         PAYLOAD_LEN = PSC_PAYLOAD_LEN,
   parameter logic [7:0] TRIG_B0     = PSC_TRIG_B0,
   parameter logic [7:0] TRIG_B1     = PSC_TRIG_B1,
   parameter int         TIMEOUT     = PSC_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     rx_is_k,
   output logic                     frame_valid,
   output logic [8*PAYLOAD_LEN-1:0] frame_payload,
   output logic                     trigger,
   output logic                     frame_error,
   output logic [1:0]               error_code,
   output logic [15:0]              frame_count,
   output logic [15:0]              error_count
);

   localparam int         TW       = $clog2(TIMEOUT + 1);
   localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   rx_state_t r_state, w_state_next;
   logic [3:0]    r_cnt;
   logic [TW-1:0] r_tmo;

   logic       w_is_sop, w_is_eop, w_bad_k, w_tmo_hit, w_in_frame;
   logic       w_store, w_good, w_err;
   err_code_t  w_code;
   logic [PAYLOAD_LEN-1:0]   w_match;
   logic [8*PAYLOAD_LEN-1:0] w_shadow;

   logic                     r_fv, r_trig, r_fe;
   err_code_t                r_code;
   logic [8*PAYLOAD_LEN-1:0] r_payload;

   assign w_is_sop   = rx_valid && rx_is_k && (rx_data == SOP);
   assign w_is_eop   = rx_valid && rx_is_k && (rx_data == EOP);
   assign w_bad_k    = rx_valid && rx_is_k && !w_is_sop;
   assign w_in_frame = (r_state != IDLE);
   assign w_tmo_hit  = w_in_frame && !rx_valid && (r_tmo == TMO_LAST);

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:
            if (w_is_sop) w_state_next = PAYLOAD;
         PAYLOAD:
            if (w_is_sop)                 w_state_next = PAYLOAD;
            else if (w_bad_k)             w_state_next = IDLE;
            else if (rx_valid && r_cnt == LAST_IDX) w_state_next = EOP_WAIT;
            else if (w_tmo_hit)           w_state_next = IDLE;
         EOP_WAIT:
            if (w_is_sop)                 w_state_next = PAYLOAD;
            else if (rx_valid || w_tmo_hit) w_state_next = IDLE;
         default:
            w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_store = 1'b0;
      w_good  = 1'b0;
      w_err   = 1'b0;
      w_code  = ERR_NONE;
      case (r_state)
         PAYLOAD: begin
            w_store = rx_valid && !rx_is_k;
            if (rx_valid && rx_is_k) begin
               w_err  = 1'b1;
               w_code = ERR_BAD_K;
            end
         end
         EOP_WAIT: begin
            w_good = w_is_eop;
            if (rx_valid && !w_is_eop) begin
               w_err  = 1'b1;
               w_code = ERR_BAD_EOP;
            end
         end
         default: ;
      endcase
      if (w_tmo_hit) begin
         w_err  = 1'b1;
         w_code = ERR_TIMEOUT;
      end
   end

   // Any SOP restarts the byte index, whether it opens or resyncs a frame.
   always_ff @(posedge clk) begin
      if (reset || w_is_sop)
         r_cnt <= '0;
      else if (w_store)
         r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || !w_in_frame || rx_valid || w_tmo_hit)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + 1'b1;
   end

   // Partial frames land in this shadow; only a good EOP copies it out.
   for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_byte
      logic [7:0] r_byte;
      always_ff @(posedge clk) begin
         if (reset)
            r_byte <= '0;
         else if (w_store && (r_cnt == 4'(gi)))
            r_byte <= rx_data;
      end
      assign w_shadow[gi*8 +: 8] = r_byte;
      if (gi == 0) begin : g_b0
         assign w_match[gi] = (r_byte == TRIG_B0);
      end else if (gi == 1) begin : g_b1
         assign w_match[gi] = (r_byte == TRIG_B1);
      end else begin : g_bz
         assign w_match[gi] = (r_byte == 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fv      <= 1'b0;
         r_trig    <= 1'b0;
         r_fe      <= 1'b0;
         r_code    <= ERR_NONE;
         r_payload <= '0;
      end else begin
         r_fv   <= w_good;
         r_trig <= w_good && (&w_match);
         r_fe   <= w_err;
         if (w_err)
            r_code <= w_code;
         if (w_good)
            r_payload <= w_shadow;
      end
   end

   psc_sat_counter #(.W(16)) u_frame_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_good),
      .o_count (frame_count)
   );

   psc_sat_counter #(.W(16)) u_error_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_err),
      .o_count (error_count)
   );

   assign frame_valid   = r_fv;
   assign trigger       = r_trig;
   assign frame_error   = r_fe;
   assign error_code    = r_code;
   assign frame_payload = r_payload;

endmodule

// File: tb/tb_psc_trigger_frame_rx.sv
// Directed vector table, hand-written corner sequences and randomized frames,
// all compared against a queue-based frame model of the receiver.
module tb_psc_trigger_frame_rx;
   import psc_trigger_pkg::*;

   logic        clk = 1'b0;
   logic        reset, rx_valid, rx_is_k;
   logic [7:0]  rx_data;
   logic        frame_valid, trigger, frame_error;
   logic [63:0] frame_payload;
   logic [1:0]  error_code;
   logic [15:0] frame_count, error_count;

   psc_trigger_frame_rx dut (
      .clk           (clk),
      .reset         (reset),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_is_k       (rx_is_k),
      .frame_valid   (frame_valid),
      .frame_payload (frame_payload),
      .trigger       (trigger),
      .frame_error   (frame_error),
      .error_code    (error_code),
      .frame_count   (frame_count),
      .error_count   (error_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: a frame is "open" after SOP; collected bytes live in a queue.
   bit          m_open;
   byte unsigned m_q[$];
   int          m_idle;
   logic [63:0] m_pay;
   bit          m_fv, m_trig, m_fe;
   logic [1:0]  m_code;
   int          m_fc, m_ec;

   function automatic void m_reset();
      m_open = 0; m_q.delete(); m_idle = 0; m_pay = '0;
      m_fv = 0; m_trig = 0; m_fe = 0; m_code = 0; m_fc = 0; m_ec = 0;
   endfunction

   function automatic void m_error(int code);
      m_fe = 1; m_code = 2'(code);
      if (m_ec < 65535) m_ec++;
   endfunction

   function automatic void m_good();
      int sum_rest = 0;
      for (int i = 0; i < 8; i++) m_pay[i*8 +: 8] = m_q[i];
      for (int i = 2; i < 8; i++) sum_rest += m_q[i];
      m_fv   = 1;
      m_trig = (m_q[0] == PSC_TRIG_B0) && (m_q[1] == PSC_TRIG_B1) && (sum_rest == 0);
      if (m_fc < 65535) m_fc++;
      m_open = 0;
   endfunction

   function automatic void m_step(bit v, logic [7:0] d, bit k);
      bit sop;
      sop = v && k && (d == PSC_SOP);
      m_fv = 0; m_trig = 0; m_fe = 0;
      if (!m_open) begin
         if (sop) begin m_open = 1; m_q.delete(); m_idle = 0; end
      end else if (!v) begin
         m_idle++;
         if (m_idle == PSC_TIMEOUT) begin m_error(3); m_open = 0; end
      end else begin
         m_idle = 0;
         if (m_q.size() < 8) begin
            if (!k)       m_q.push_back(d);
            else if (sop) begin m_error(1); m_q.delete(); end
            else          begin m_error(1); m_open = 0; end
         end else begin
            if (k && d == PSC_EOP) m_good();
            else if (sop)          begin m_error(2); m_q.delete(); end
            else                   begin m_error(2); m_open = 0; end
         end
      end
   endfunction

   function automatic logic [127:0] dut_vec();
      return {27'b0, frame_valid, trigger, frame_error, error_code,
              frame_count, error_count, frame_payload};
   endfunction

   function automatic logic [127:0] model_vec();
      return {27'b0, m_fv, m_trig, m_fe, m_code, m_fc[15:0], m_ec[15:0], m_pay};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic apply(input bit v, input logic [7:0] d, input bit k);
      rx_valid = v; rx_data = d; rx_is_k = k;
      @(posedge clk);
      cyc++;
      m_step(v, d, k);
      #1;
      chk("model", dut_vec(), model_vec());
   endtask

   task automatic do_reset();
      reset = 1; rx_valid = 0; rx_data = 0; rx_is_k = 0;
      @(posedge clk);
      cyc++;
      m_reset();
      #1;
      chk("reset_state", dut_vec(), model_vec());
      chk("reset_no_err", 128'(frame_error), 128'(0));
      reset = 0;
   endtask

   task automatic send_frame(input logic [63:0] p);
      apply(1, PSC_SOP, 1);
      for (int i = 0; i < 8; i++) apply(1, p[i*8 +: 8], 0);
      apply(1, PSC_EOP, 1);
   endtask

   typedef struct {
      bit         rst_before;
      bit         v;
      bit         k;
      logic [7:0] d;
      bit         fv;
      bit         trig;
      bit         fe;
      logic [1:0] code;
   } vec_t;

   vec_t tbl[$];

   function automatic void push(bit r, bit k, logic [7:0] d, bit fv, bit tr, bit fe, logic [1:0] c);
      vec_t t;
      t.rst_before = r; t.v = 1; t.k = k; t.d = d;
      t.fv = fv; t.trig = tr; t.fe = fe; t.code = c;
      tbl.push_back(t);
   endfunction

   logic [63:0] p_good, p_trig;
   logic [7:0]  fb[$];
   bit          fk[$];
   int          mode, pos, stall_pos;

   initial begin
      reset = 1; rx_valid = 0; rx_data = 0; rx_is_k = 0;
      p_good = 64'h8877_6655_4433_2211;
      p_trig = 64'h0000_0000_0000_3001;

      // Trigger frame, back-to-back bytes.
      push(1, 1, 8'h3C, 0, 0, 0, 0);
      push(0, 0, 8'h01, 0, 0, 0, 0);
      push(0, 0, 8'h30, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) push(0, 0, 8'h00, 0, 0, 0, 0);
      push(0, 1, 8'hBC, 1, 1, 0, 0);
      // Mid-frame SOP resync, then a good trigger frame.
      push(1, 1, 8'h3C, 0, 0, 0, 0);
      push(0, 0, 8'h01, 0, 0, 0, 0);
      push(0, 0, 8'h30, 0, 0, 0, 0);
      push(0, 1, 8'h3C, 0, 0, 1, 1);
      push(0, 0, 8'h01, 0, 0, 0, 1);
      push(0, 0, 8'h30, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) push(0, 0, 8'h00, 0, 0, 0, 1);
      push(0, 1, 8'hBC, 1, 1, 0, 1);

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) begin
            if (i != 0) chk("trig_frame_count", 128'(frame_count), 128'(1));
            do_reset();
         end
         apply(tbl[i].v, tbl[i].d, tbl[i].k);
         chk("table", 128'({frame_valid, trigger, frame_error, error_code}),
             128'({tbl[i].fv, tbl[i].trig, tbl[i].fe, tbl[i].code}));
      end
      chk("midsop_payload", 128'(frame_payload), 128'(p_trig));
      chk("midsop_frame_count", 128'(frame_count), 128'(1));
      chk("midsop_error_count", 128'(error_count), 128'(1));

      // Null frame with rx_valid toggling every other cycle.
      do_reset();
      apply(1, PSC_SOP, 1);
      apply(0, 8'hFF, 1);
      for (int i = 0; i < 8; i++) begin
         apply(1, 8'h00, 0);
         apply(0, 8'hA5, 0);
      end
      apply(1, PSC_EOP, 1);
      chk("null_fv_trig", 128'({frame_valid, trigger}), 128'(2'b10));
      chk("null_payload", 128'(frame_payload), 128'(0));
      chk("null_error_count", 128'(error_count), 128'(0));

      // Bad EOP after a good frame leaves the old payload in place.
      send_frame(p_good);
      chk("good_payload", 128'(frame_payload), 128'(p_good));
      apply(1, PSC_SOP, 1);
      for (int i = 0; i < 8; i++) apply(1, 8'hAA, 0);
      apply(1, 8'h55, 0);
      chk("bad_eop_flags", 128'({frame_valid, frame_error, error_code}), 128'(4'b0110));
      chk("bad_eop_payload", 128'(frame_payload), 128'(p_good));

      // Timeout: error only on the 64th idle cycle.
      apply(1, PSC_SOP, 1);
      apply(1, 8'h01, 0);
      repeat (63) apply(0, 8'h00, 0);
      chk("tmo_not_yet", 128'(frame_error), 128'(0));
      apply(0, 8'h00, 0);
      chk("tmo_flags", 128'({frame_error, error_code}), 128'(3'b111));
      send_frame(p_trig);
      chk("after_tmo_frame", 128'({frame_valid, trigger}), 128'(2'b11));

      // Reset after four payload bytes, then a full frame.
      apply(1, PSC_SOP, 1);
      for (int i = 0; i < 4; i++) apply(1, 8'h11, 0);
      do_reset();
      send_frame(p_good);
      chk("post_reset_frame", 128'({frame_valid, frame_count, frame_payload}),
          128'({1'b1, 16'd1, p_good}));

      // Randomized frames with stalls, idle fill and corruptions.
      for (int f = 0; f < 80; f++) begin
         mode = $urandom_range(0, 9);
         repeat ($urandom_range(0, 3)) begin
            if ($urandom_range(0, 1) == 1) apply(0, 8'($urandom), 0);
            else if ($urandom_range(0, 1) == 1) apply(1, PSC_EOP, 1);
            else apply(1, 8'($urandom), 0);
         end
         fb.delete(); fk.delete();
         fb.push_back(PSC_SOP); fk.push_back(1);
         for (int i = 0; i < 8; i++) begin
            if (mode == 3) fb.push_back(i == 0 ? PSC_TRIG_B0 : i == 1 ? PSC_TRIG_B1 : 8'h00);
            else if ($urandom_range(0, 3) == 0) fb.push_back(8'h00);
            else fb.push_back(8'($urandom));
            fk.push_back(0);
         end
         fb.push_back(PSC_EOP); fk.push_back(1);
         if (mode == 0) begin
            pos = $urandom_range(1, 9);
            fb[pos] = ($urandom_range(0, 1) == 1) ? PSC_SOP : 8'hF7;
            fk[pos] = 1;
         end else if (mode == 1) begin
            fb[9] = 8'($urandom); fk[9] = 0;
         end
         stall_pos = (mode == 2) ? $urandom_range(1, 9) : 99;
         for (int i = 0; i < 10; i++) begin
            if (i == stall_pos) repeat (62 + $urandom_range(0, 4)) apply(0, 8'h00, 0);
            if ($urandom_range(0, 3) == 0) apply(0, 8'($urandom), 1);
            apply(1, fb[i], fk[i]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
